// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arms on start, writes CAPTURE_LEN triggered samples into a single-port
// buffer, then reads them back in order and streams them downstream over valid/ready.
module adc_capture_ctrl #(
  parameter int unsigned   AW          = 13,
  parameter int unsigned   DW          = 10,
  parameter int unsigned   CAPTURE_LEN = 8192,
  parameter bit            TRIG_EN     = 1'b1,
  parameter logic [DW-1:0] TRIG_LEVEL  = DW'(600)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LastAddr = AW'(CAPTURE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDrain} state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic          rd_all_q;
  logic [AW-1:0] acc_cnt_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          fifo_wr_q;
  logic          fifo_rd_q;
  logic [1:0]    fifo_cnt_q;
  logic [AW-1:0] ad_q;
  logic [DW-1:0] din_q;
  logic          done_q;

  logic          trigger;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          accept;
  logic [1:0]    occ;
  logic          last_write;
  logic          last_accept;

  // Buffer access decode; occupancy counts this cycle's pop so the drain sustains 1 beat/cycle.
  always_comb begin
    trigger     = adc_valid & (!TRIG_EN | (adc_data >= TRIG_LEVEL));
    wr_addr     = (state_q == StArm) ? '0 : wptr_q;
    wr_en       = !abort & (((state_q == StArm) & trigger) |
                            ((state_q == StCapture) & adc_valid));
    accept      = (fifo_cnt_q != 2'd0) & out_ready;
    occ         = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, accept};
    rd_en       = !abort & (state_q == StDrain) & !rd_all_q & (occ < 2'd2);
    last_write  = wr_en & (wr_addr == LastAddr);
    last_accept = accept & (acc_cnt_q == LastAddr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start) state_d = StArm;
        StArm:     if (wr_en) state_d = last_write ? StDrain : StCapture;
        StCapture: if (last_write) state_d = StDrain;
        StDrain:   if (last_accept) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ram_ce    = wr_en | rd_en;
    ram_oce   = wr_en | rd_en;
    ram_wre   = wr_en;
    ram_ad    = wr_en ? wr_addr : (rd_en ? rptr_q : ad_q);
    ram_din   = wr_en ? adc_data : din_q;
    out_valid = (fifo_cnt_q != 2'd0);
    out_data  = out_valid ? fifo_q[fifo_rd_q] : '0;
    busy      = (state_q != StIdle);
    done      = done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_all_q   <= 1'b0;
      acc_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      ad_q       <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= !abort & (state_q == StDrain) & last_accept;
      if (ram_ce) ad_q <= ram_ad;
      if (wr_en) din_q <= adc_data;

      if ((state_q == StIdle) & start & !abort) begin
        wptr_q    <= '0;
        rptr_q    <= '0;
        rd_all_q  <= 1'b0;
        acc_cnt_q <= '0;
      end
      // Pointers saturate at the last address rather than wrapping.
      if (wr_en & !last_write) wptr_q <= wr_addr + 1'b1;
      if (rd_en) begin
        if (rptr_q == LastAddr) rd_all_q <= 1'b1;
        else                    rptr_q   <= rptr_q + 1'b1;
      end
      if (accept & !last_accept) acc_cnt_q <= acc_cnt_q + 1'b1;

      if (abort) begin
        inflight_q <= 1'b0;
        fifo_wr_q  <= 1'b0;
        fifo_rd_q  <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        inflight_q <= rd_en;
        if (inflight_q) begin
          fifo_q[fifo_wr_q] <= ram_dout;
          fifo_wr_q         <= ~fifo_wr_q;
        end
        if (accept) fifo_rd_q <= ~fifo_rd_q;
        fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, accept};
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: two instances (full-size triggered, and 4-sample free-running)
// each with a behavioural buffer, checked against a transaction-level capture/stream model.
module tb_adc_capture_ctrl;

  localparam int AW        = 13;
  localparam int DW        = 10;
  localparam int BigLen    = 8192;
  localparam int SmallLen  = 4;
  localparam int TrigLevel = 600;

  logic          clk = 1'b0;
  logic          reset, start, abort, adc_valid, out_ready;
  logic [DW-1:0] adc_data;

  logic          b_ce, b_oce, b_wre, b_valid, b_busy, b_done;
  logic [AW-1:0] b_ad;
  logic [DW-1:0] b_din, b_dout, b_data;
  logic          s_ce, s_oce, s_wre, s_valid, s_busy, s_done;
  logic [AW-1:0] s_ad;
  logic [DW-1:0] s_din, s_dout, s_data;

  always #5 clk = ~clk;

  adc_capture_ctrl u_big (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .adc_data(adc_data),
    .adc_valid(adc_valid), .ram_ce(b_ce), .ram_oce(b_oce), .ram_wre(b_wre), .ram_ad(b_ad),
    .ram_din(b_din), .ram_dout(b_dout), .out_data(b_data), .out_valid(b_valid),
    .out_ready(out_ready), .busy(b_busy), .done(b_done)
  );

  adc_capture_ctrl #(.CAPTURE_LEN(SmallLen), .TRIG_EN(1'b0)) u_small (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .adc_data(adc_data),
    .adc_valid(adc_valid), .ram_ce(s_ce), .ram_oce(s_oce), .ram_wre(s_wre), .ram_ad(s_ad),
    .ram_din(s_din), .ram_dout(s_dout), .out_data(s_data), .out_valid(s_valid),
    .out_ready(out_ready), .busy(s_busy), .done(s_done)
  );

  // Single-port buffers with one-cycle read latency.
  logic [DW-1:0] b_mem [2**AW];
  logic [DW-1:0] s_mem [2**AW];
  always @(posedge clk) if (b_ce) begin
    if (b_wre) b_mem[b_ad] <= b_din;
    else       b_dout <= b_mem[b_ad];
  end
  always @(posedge clk) if (s_ce) begin
    if (s_wre) s_mem[s_ad] <= s_din;
    else       s_dout <= s_mem[s_ad];
  end

  bit            sel;
  logic          o_ce, o_oce, o_wre, o_valid, o_busy, o_done;
  logic [AW-1:0] o_ad;
  logic [DW-1:0] o_din, o_data;
  assign o_ce    = sel ? s_ce    : b_ce;
  assign o_oce   = sel ? s_oce   : b_oce;
  assign o_wre   = sel ? s_wre   : b_wre;
  assign o_ad    = sel ? s_ad    : b_ad;
  assign o_din   = sel ? s_din   : b_din;
  assign o_data  = sel ? s_data  : b_data;
  assign o_valid = sel ? s_valid : b_valid;
  assign o_busy  = sel ? s_busy  : b_busy;
  assign o_done  = sel ? s_done  : b_done;

  typedef enum int {MIdle, MArm, MCap, MDrain} mphase_e;
  mphase_e       ph;
  int            len;
  bit            trig_en;
  logic [DW-1:0] exp_q [$];
  int            wcnt, nrd, nacc;
  logic [AW-1:0] last_ad;
  logic [DW-1:0] last_din;
  bit            done_exp, stall_prev;
  logic [DW-1:0] stall_data;
  int            cyc, drain_cyc, first_acc, last_acc;
  int            vmode, dmode, rmode, ramp;
  int            tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = MIdle; done_exp = 0; stall_prev = 0; last_ad = '0; last_din = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ce", o_ce, 0);      chk("rst_oce", o_oce, 0);   chk("rst_wre", o_wre, 0);
    chk("rst_ad", o_ad, 0);      chk("rst_din", o_din, 0);   chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0); chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0);
  endtask

  task automatic drive_inputs();
    case (vmode)
      0:       adc_valid = 1'b1;
      1:       adc_valid = ($urandom_range(9) < 7);
      default: adc_valid = (cyc % 3 == 0);
    endcase
    if (dmode != 0) adc_data = DW'($urandom_range(1023));
    else begin
      adc_data = DW'(ramp);
      ramp = (ramp + 1) % 1024;
    end
    out_ready = (rmode != 0) ? 1'($urandom_range(1)) : 1'b1;
  endtask

  // One clock: check what the DUT presents before the edge, then advance the model.
  task automatic step();
    bit wr_exp, acc;
    @(negedge clk);
    cyc++;
    wr_exp = !abort && adc_valid &&
             ((ph == MArm && (!trig_en || adc_data >= TrigLevel)) || ph == MCap);
    acc = o_valid && out_ready;
    chk("busy", o_busy, (ph != MIdle));
    chk("done", o_done, done_exp);
    if (stall_prev) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, stall_data);
    end
    if (ph != MDrain) chk("valid_outside_drain", o_valid, 0);
    if (!abort) begin
      if (wr_exp) begin
        chk("wr_ce", o_ce, 1);   chk("wr_oce", o_oce, 1); chk("wr_wre", o_wre, 1);
        chk("wr_ad", o_ad, wcnt); chk("wr_din", o_din, adc_data);
      end else if (ph == MDrain) begin
        chk("rd_wre", o_wre, 0);
        if (o_ce) begin
          chk("rd_oce", o_oce, 1);
          chk("rd_ad", o_ad, nrd);
          chk("rd_din_hold", o_din, last_din);
          chk("rd_in_range", (nrd < len), 1);
          chk("rd_ahead", (nrd - (nacc + int'(acc)) < 2), 1);
        end else chk("rd_oce_off", o_oce, 0);
      end else begin
        chk("idle_ce", o_ce, 0); chk("idle_oce", o_oce, 0); chk("idle_wre", o_wre, 0);
      end
      if (!o_ce) begin
        chk("hold_ad", o_ad, last_ad);
        chk("hold_din", o_din, last_din);
      end
    end
    if (o_ce) last_ad = o_ad;
    if (o_ce && o_wre) last_din = o_din;
    if (acc && ph == MDrain && !abort) begin
      chk("beat_in_range", (nacc < exp_q.size()), 1);
      if (nacc < exp_q.size()) chk("out_data", o_data, exp_q[nacc]);
      if (nacc == 0) first_acc = cyc;
      last_acc = cyc;
    end
    stall_prev = o_valid && !out_ready && !abort && ph == MDrain;
    stall_data = o_data;
    done_exp = 0;
    if (abort) ph = MIdle;
    else case (ph)
      MIdle: if (start) begin
        ph = MArm; wcnt = 0; nrd = 0; nacc = 0; exp_q.delete();
      end
      MArm, MCap: if (wr_exp) begin
        exp_q.push_back(adc_data);
        wcnt++;
        if (wcnt == len) begin
          ph = MDrain;
          drain_cyc = cyc + 1;
        end else ph = MCap;
      end
      default: begin
        if (o_ce && !o_wre) nrd++;
        if (acc) begin
          nacc++;
          if (nacc == len) begin ph = MIdle; done_exp = 1; end
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic capture_run(input int abort_at);
    bit fin;
    fin = 0;
    start = 1'b1;
    drive_inputs();
    step();
    start = 1'b0;
    for (int i = 0; i < 30000 && !fin; i++) begin
      start = (i == 1);  // arrives while busy
      drive_inputs();
      abort = (abort_at >= 0 && ph == MDrain && nacc == abort_at);
      step();
      if (abort || ph == MIdle) fin = 1;
      abort = 1'b0;
    end
    start = 1'b0;
    chk("run_finished", fin, 1);
  endtask

  task automatic idle_steps(input int n);
    start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; ramp = 0;
    sel = 0; len = BigLen; trig_en = 1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Ramp capture, drain at full rate.
    vmode = 0; dmode = 0; rmode = 0; ramp = 0;
    capture_run(-1);
    chk("beats", nacc, BigLen);
    chk("first_latency", first_acc - drain_cyc, 2);
    chk("throughput", last_acc - first_acc, BigLen - 1);
    chk("mem_first", b_mem[0], 600);
    chk("mem_last", b_mem[BigLen-1], (600 + BigLen - 1) % 1024);
    idle_steps(3);

    // Random data, sparse valid, random backpressure.
    vmode = 1; dmode = 1; rmode = 1;
    capture_run(-1);
    chk("beats_random", nacc, BigLen);
    idle_steps(3);

    // Abort after 100 beats, then a fresh capture starts at address 0.
    vmode = 0; dmode = 0; rmode = 0; ramp = 0;
    capture_run(100);
    chk("aborted_at", nacc, 100);
    idle_steps(3);
    chk("abort_busy", o_busy, 0);
    start = 1'b1;
    drive_inputs();
    step();
    start = 1'b0;
    for (int i = 0; i < 2000 && wcnt < 20; i++) begin
      drive_inputs();
      step();
    end
    chk("fresh_capture_progress", wcnt, 20);

    // Asynchronous reset mid-capture.
    adc_valid = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs();
    step();
    reset = 1'b0;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    idle_steps(2);
    chk("start_abort_idle", o_busy, 0);

    // Four-sample capture without trigger, valid every third cycle.
    pulse_reset();
    sel = 1; len = SmallLen; trig_en = 0;
    vmode = 2; dmode = 1; rmode = 0;
    capture_run(-1);
    chk("beats_small", nacc, SmallLen);
    chk("small_mem3", s_mem[3], exp_q[3]);
    idle_steps(3);
    chk("small_busy_after", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
